// File: rtl/abc80_kbd_pkg.sv
// abc80_kbd_pkg
// Shared definitions for the ABC80 keyboard front end: modifier scancodes,
// output-latch state encoding, keymap ROM entry layout and a letter test.
package abc80_kbd_pkg;

    // Set-2 scancodes of the keys that only change modifier state
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } kbd_state_t;

    typedef struct packed {
        logic [6:0] base;
        logic [6:0] shifted;
    } rom_entry_t;

    // Letters are recognised by their unshifted code, which covers a..z
    // plus the Swedish letters placed at 0x7B..0x7D.
    function automatic logic is_letter(input logic [6:0] code);
        return (code >= 7'h61) && (code <= 7'h7D);
    endfunction

endpackage

// File: rtl/abc80_keyrom.sv
// abc80_keyrom
// 256 x 14 keymap ROM indexed by {ext, scancode[6:0]}, one cycle read latency.
// Ports:
//   clk_sys : system clock
//   addr    : {E0-extended flag, scancode[6:0]}
//   data    : {base code, shifted code}, valid the cycle after addr
module abc80_keyrom
    import abc80_kbd_pkg::*;
(
    input  logic       clk_sys,
    input  logic [7:0] addr,
    output rom_entry_t data
);

    rom_entry_t data_d;
    rom_entry_t data_q;

    // Constant keymap; every unlisted address (function keys included) reads 0
    function automatic rom_entry_t lookup(input logic [7:0] a);
        rom_entry_t e;
        case (a)
            8'h1C: e = {7'h61, 7'h41};  // a
            8'h32: e = {7'h62, 7'h42};  // b
            8'h21: e = {7'h63, 7'h43};  // c
            8'h23: e = {7'h64, 7'h44};  // d
            8'h24: e = {7'h65, 7'h45};  // e
            8'h2B: e = {7'h66, 7'h46};  // f
            8'h34: e = {7'h67, 7'h47};  // g
            8'h33: e = {7'h68, 7'h48};  // h
            8'h43: e = {7'h69, 7'h49};  // i
            8'h3B: e = {7'h6A, 7'h4A};  // j
            8'h42: e = {7'h6B, 7'h4B};  // k
            8'h4B: e = {7'h6C, 7'h4C};  // l
            8'h3A: e = {7'h6D, 7'h4D};  // m
            8'h31: e = {7'h6E, 7'h4E};  // n
            8'h44: e = {7'h6F, 7'h4F};  // o
            8'h4D: e = {7'h70, 7'h50};  // p
            8'h15: e = {7'h71, 7'h51};  // q
            8'h2D: e = {7'h72, 7'h52};  // r
            8'h1B: e = {7'h73, 7'h53};  // s
            8'h2C: e = {7'h74, 7'h54};  // t
            8'h3C: e = {7'h75, 7'h55};  // u
            8'h2A: e = {7'h76, 7'h56};  // v
            8'h1D: e = {7'h77, 7'h57};  // w
            8'h22: e = {7'h78, 7'h58};  // x
            8'h35: e = {7'h79, 7'h59};  // y
            8'h1A: e = {7'h7A, 7'h5A};  // z
            8'h54: e = {7'h7D, 7'h5D};  // aa (ring)
            8'h52: e = {7'h7B, 7'h5B};  // ae
            8'h4C: e = {7'h7C, 7'h5C};  // oe
            8'h16: e = {7'h31, 7'h21};  // 1 !
            8'h1E: e = {7'h32, 7'h22};  // 2 "
            8'h26: e = {7'h33, 7'h23};  // 3 #
            8'h25: e = {7'h34, 7'h24};  // 4 $
            8'h2E: e = {7'h35, 7'h25};  // 5 %
            8'h36: e = {7'h36, 7'h26};  // 6 &
            8'h3D: e = {7'h37, 7'h2F};  // 7 /
            8'h3E: e = {7'h38, 7'h28};  // 8 (
            8'h46: e = {7'h39, 7'h29};  // 9 )
            8'h45: e = {7'h30, 7'h3D};  // 0 =
            8'h41: e = {7'h2C, 7'h3B};  // , ;
            8'h49: e = {7'h2E, 7'h3A};  // . :
            8'h4A: e = {7'h2D, 7'h5F};  // - _
            8'h4E: e = {7'h2B, 7'h3F};  // + ?
            8'h29: e = {7'h20, 7'h20};  // space
            8'h5A: e = {7'h0D, 7'h0D};  // enter
            8'h66: e = {7'h08, 7'h08};  // backspace
            8'h76: e = {7'h1B, 7'h1B};  // esc
            8'h0D: e = {7'h09, 7'h09};  // tab
            8'hEB: e = {7'h08, 7'h08};  // E0 6B cursor left
            8'hF4: e = {7'h09, 7'h09};  // E0 74 cursor right
            8'hDA: e = {7'h0D, 7'h0D};  // E0 5A keypad enter
            default: e = {7'h00, 7'h00};
        endcase
        return e;
    endfunction

    // ROM read decode
    always_comb begin
        data_d = lookup(addr);
    end

    // ROM output register; contents are constant so no reset is needed
    always_ff @(posedge clk_sys) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/abc80_keymap.sv
// abc80_keymap
// PS/2 event word to ABC80 character front end with modifier tracking,
// caps lock, a type-ahead FIFO and a hold-until-acknowledged output latch.
// Ports:
//   clk_sys   : system clock
//   reset     : synchronous active-high reset
//   ps2_key   : [10] event toggle, [9] press, [8] E0 extended, [7:0] scancode
//   key_ack   : one-cycle pulse, core has read the latch
//   key_code  : latched ABC80 character code
//   key_valid : latch holds an unacknowledged character
//   upcase    : caps-lock state
//   overflow  : one-cycle pulse when a character is dropped on a full FIFO
module abc80_keymap
    import abc80_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        key_ack,
    output logic [6:0]  key_code,
    output logic        key_valid,
    output logic        upcase,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};

    logic        tog_q, tog_d;
    logic        lshift_q, lshift_d, rshift_q, rshift_d;
    logic        ctrl_q, ctrl_d, upcase_q, upcase_d;
    logic        s1_valid_q, s1_valid_d, s1_shift_q, s1_shift_d;
    logic        s1_ctrl_q, s1_ctrl_d, s1_upcase_q, s1_upcase_d;
    logic        s1_unmapped_q, s1_unmapped_d;
    logic        s2_valid_q, s2_valid_d;
    logic [6:0]  s2_code_q, s2_code_d;
    logic [6:0]  mem_q [FIFO_DEPTH];
    logic [6:0]  mem_d [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    kbd_state_t  state_q, state_d;
    logic [6:0]  key_code_q, key_code_d;

    logic        event_s, press_s, ext_s;
    logic [7:0]  sc_s;
    logic        is_lshift_s, is_rshift_s, is_ctrl_s, is_caps_s, is_mod_s;
    rom_entry_t  rom_s;
    logic        letter_s;
    logic [6:0]  xlat_s;
    logic        empty_s, full_s, push_ok_s, pop_s;

    assign event_s     = ps2_key[10] ^ tog_q;
    assign press_s     = ps2_key[9];
    assign ext_s       = ps2_key[8];
    assign sc_s        = ps2_key[7:0];
    // E0 12 is a fake shift sent around some extended keys, so shift and
    // caps only match the plain codes; ctrl matches both sides.
    assign is_lshift_s = !ext_s && (sc_s == SC_LSHIFT);
    assign is_rshift_s = !ext_s && (sc_s == SC_RSHIFT);
    assign is_caps_s   = !ext_s && (sc_s == SC_CAPS);
    assign is_ctrl_s   = (sc_s == SC_CTRL);
    assign is_mod_s    = is_lshift_s | is_rshift_s | is_caps_s | is_ctrl_s;

    abc80_keyrom u_rom (
        .clk_sys (clk_sys),
        .addr    ({ext_s, sc_s[6:0]}),
        .data    (rom_s)
    );

    // Event stage: modifier updates and capture of pre-event modifier state
    always_comb begin
        tog_d = ps2_key[10];
        if (event_s && is_lshift_s) lshift_d = press_s; else lshift_d = lshift_q;
        if (event_s && is_rshift_s) rshift_d = press_s; else rshift_d = rshift_q;
        if (event_s && is_ctrl_s)   ctrl_d   = press_s; else ctrl_d   = ctrl_q;
        if (event_s && is_caps_s && press_s) upcase_d = !upcase_q; else upcase_d = upcase_q;
        s1_valid_d    = event_s && press_s && !is_mod_s;
        s1_shift_d    = lshift_q | rshift_q;
        s1_ctrl_d     = ctrl_q;
        s1_upcase_d   = upcase_q;
        s1_unmapped_d = sc_s[7];
    end

    // Translate stage: ROM entry plus captured modifiers to final code
    always_comb begin
        letter_s = is_letter(rom_s.base);
        if (s1_unmapped_q) begin
            // ROM index drops scancode bit 7, so codes >= 0x80 must be masked here
            xlat_s = 7'h00;
        end else if (s1_ctrl_q && letter_s) begin
            xlat_s = rom_s.base & 7'h1F;
        end else if (letter_s) begin
            xlat_s = (s1_shift_q ^ s1_upcase_q) ? rom_s.shifted : rom_s.base;
        end else begin
            xlat_s = s1_shift_q ? rom_s.shifted : rom_s.base;
        end
        s2_valid_d = s1_valid_q && (xlat_s != 7'h00);
        s2_code_d  = xlat_s;
    end

    // FIFO: full is judged before any same-cycle pop
    always_comb begin
        empty_s   = (wr_ptr_q == rd_ptr_q);
        full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push_ok_s = s2_valid_q && !full_s;
        mem_d     = mem_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = s2_code_q;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) rd_ptr_d = rd_ptr_q + PTR_ONE; else rd_ptr_d = rd_ptr_q;
        overflow_d = s2_valid_q && full_s;
    end

    // Latch FSM next state
    always_comb begin
        case (state_q)
            IDLE:    state_d = empty_s ? IDLE : HOLD;
            HOLD:    state_d = key_ack ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // Latch FSM outputs: pop and key_code load
    always_comb begin
        case (state_q)
            IDLE:    pop_s = !empty_s;
            HOLD:    pop_s = 1'b0;
            default: pop_s = 1'b0;
        endcase
        if (pop_s) key_code_d = mem_q[rd_ptr_q[AW-1:0]]; else key_code_d = key_code_q;
    end

    // Latch FSM state register
    always_ff @(posedge clk_sys) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Pipeline, modifier, pointer and output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tog_q         <= ps2_key[10];
            lshift_q      <= 1'b0;
            rshift_q      <= 1'b0;
            ctrl_q        <= 1'b0;
            upcase_q      <= 1'b1;
            s1_valid_q    <= 1'b0;
            s1_shift_q    <= 1'b0;
            s1_ctrl_q     <= 1'b0;
            s1_upcase_q   <= 1'b0;
            s1_unmapped_q <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_code_q     <= 7'h00;
            wr_ptr_q      <= PTR_ZERO;
            rd_ptr_q      <= PTR_ZERO;
            overflow_q    <= 1'b0;
            key_code_q    <= 7'h00;
        end else begin
            tog_q         <= tog_d;
            lshift_q      <= lshift_d;
            rshift_q      <= rshift_d;
            ctrl_q        <= ctrl_d;
            upcase_q      <= upcase_d;
            s1_valid_q    <= s1_valid_d;
            s1_shift_q    <= s1_shift_d;
            s1_ctrl_q     <= s1_ctrl_d;
            s1_upcase_q   <= s1_upcase_d;
            s1_unmapped_q <= s1_unmapped_d;
            s2_valid_q    <= s2_valid_d;
            s2_code_q     <= s2_code_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            overflow_q    <= overflow_d;
            key_code_q    <= key_code_d;
        end
    end

    // FIFO storage; emptiness is owned by the pointers so data needs no reset
    always_ff @(posedge clk_sys) begin
        mem_q <= mem_d;
    end

    assign key_code  = key_code_q;
    assign key_valid = (state_q == HOLD);
    assign upcase    = upcase_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_abc80_keymap.sv
// tb_abc80_keymap
// Self-checking bench: table-driven key vectors, hand-written multi-cycle
// sequences and random traffic, all checked every cycle against a
// queue-based reference model.
module tb_abc80_keymap;

    localparam int DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        key_ack;
    logic [6:0]  key_code;
    logic        key_valid;
    logic        upcase;
    logic        overflow;

    always #5 clk_sys = ~clk_sys;

    abc80_keymap #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .key_ack   (key_ack),
        .key_code  (key_code),
        .key_valid (key_valid),
        .upcase    (upcase),
        .overflow  (overflow)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int ovf_cnt = 0;

    // reference model state
    typedef struct { int due; logic [6:0] code; } pend_t;
    pend_t      pend[$];
    logic [6:0] mfifo[$];
    bit         m_tog, m_lsh, m_rsh, m_ctrl, m_up, m_valid, m_ovf;
    logic [6:0] m_code;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_char(bit ext, logic [7:0] sc, bit sh, bit ct, bit up);
        logic [6:0] lo, hi;
        bit letter;
        lo = 7'h00; hi = 7'h00;
        if (sc >= 8'h80) return 7'h00;
        case ({ext, sc})
            9'h01C: begin lo = 7'h61; hi = 7'h41; end
            9'h016: begin lo = 7'h31; hi = 7'h21; end
            9'h029: begin lo = 7'h20; hi = 7'h20; end
            9'h05A: begin lo = 7'h0D; hi = 7'h0D; end
            9'h066: begin lo = 7'h08; hi = 7'h08; end
            9'h076: begin lo = 7'h1B; hi = 7'h1B; end
            9'h16B: begin lo = 7'h08; hi = 7'h08; end
            9'h174: begin lo = 7'h09; hi = 7'h09; end
            default: begin lo = 7'h00; hi = 7'h00; end
        endcase
        letter = (lo >= 7'h61) && (lo <= 7'h7D);
        if (ct && letter) return lo & 7'h1F;
        if (letter) return (sh != up) ? hi : lo;
        return sh ? hi : lo;
    endfunction

    // Advance the model by one clock edge using the inputs present now
    task automatic model_edge();
        bit ev, pr, ex, full, pop;
        logic [7:0] sc;
        logic [6:0] ch;
        if (reset) begin
            m_tog = ps2_key[10]; m_lsh = 0; m_rsh = 0; m_ctrl = 0; m_up = 1;
            m_valid = 0; m_code = 7'h00; m_ovf = 0;
            pend.delete(); mfifo.delete();
            return;
        end
        m_ovf = 0;
        full = (mfifo.size() == DEPTH);
        pop  = !m_valid && (mfifo.size() != 0);
        if (m_valid && key_ack) m_valid = 0;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            if (full) m_ovf = 1;
            else mfifo.push_back(pend[0].code);
            void'(pend.pop_front());
        end
        if (pop) begin m_code = mfifo.pop_front(); m_valid = 1; end
        ev = (ps2_key[10] != m_tog);
        m_tog = ps2_key[10];
        if (ev) begin
            pr = ps2_key[9]; ex = ps2_key[8]; sc = ps2_key[7:0];
            if (!ex && sc == 8'h12) m_lsh = pr;
            else if (!ex && sc == 8'h59) m_rsh = pr;
            else if (sc == 8'h14) m_ctrl = pr;
            else if (!ex && sc == 8'h58) begin if (pr) m_up = !m_up; end
            else if (pr) begin
                ch = ref_char(ex, sc, m_lsh | m_rsh, m_ctrl, m_up);
                if (ch != 7'h00) pend.push_back('{cyc + 2, ch});
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_sys);
        @(negedge clk_sys);
        cyc++;
        check("key_valid", {7'b0, key_valid}, {7'b0, m_valid});
        check("key_code",  {1'b0, key_code},  {1'b0, m_code});
        check("upcase",    {7'b0, upcase},    {7'b0, m_up});
        check("overflow",  {7'b0, overflow},  {7'b0, m_ovf});
        if (overflow) ovf_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ack_tick();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
    endtask

    task automatic send(input bit pr, input bit ex, input logic [7:0] sc);
        ps2_key = {~ps2_key[10], pr, ex, sc};
        tick();
    endtask

    typedef struct {
        bit sh; bit ct; bit cp; bit ext;
        logic [7:0] sc; bit has; logic [6:0] exp;
    } vec_t;
    vec_t tbl[14];

    logic [7:0] pool[12];
    int ovf_before;
    int got;
    int w;

    initial begin
        // upcase starts at 1, so a plain letter press gives the capital
        tbl[0]  = '{0, 0, 0, 0, 8'h1C, 1, 7'h41};
        tbl[1]  = '{1, 0, 0, 0, 8'h1C, 1, 7'h61};
        tbl[2]  = '{0, 0, 1, 0, 8'h1C, 1, 7'h61};
        tbl[3]  = '{1, 0, 1, 0, 8'h1C, 1, 7'h41};
        tbl[4]  = '{0, 1, 0, 0, 8'h1C, 1, 7'h01};
        tbl[5]  = '{0, 0, 0, 0, 8'h16, 1, 7'h31};
        tbl[6]  = '{1, 0, 1, 0, 8'h16, 1, 7'h21};
        tbl[7]  = '{0, 0, 1, 0, 8'h16, 1, 7'h31};
        tbl[8]  = '{0, 0, 0, 0, 8'h5A, 1, 7'h0D};
        tbl[9]  = '{0, 0, 0, 0, 8'h66, 1, 7'h08};
        tbl[10] = '{0, 0, 0, 0, 8'h76, 1, 7'h1B};
        tbl[11] = '{0, 0, 0, 1, 8'h6B, 1, 7'h08};
        tbl[12] = '{1, 0, 0, 1, 8'h74, 1, 7'h09};
        tbl[13] = '{0, 0, 0, 0, 8'h05, 0, 7'h00};

        pool = '{8'h1C, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h76,
                 8'h05, 8'h83, 8'h12, 8'h59, 8'h14, 8'h58};

        reset = 1'b1; key_ack = 1'b0; ps2_key = 11'h000;
        idle(2);
        check("rst_upcase", {7'b0, upcase}, 8'h01);
        check("rst_code", {1'b0, key_code}, 8'h00);
        reset = 1'b0;
        idle(2);

        // exact latency: valid appears on the fourth edge after the event
        send(1, 0, 8'h1C);
        idle(2);
        check("lat_early", {7'b0, key_valid}, 8'h00);
        tick();
        check("lat_valid", {7'b0, key_valid}, 8'h01);
        check("lat_code", {1'b0, key_code}, 8'h41);
        ack_tick();
        check("lat_ack", {7'b0, key_valid}, 8'h00);
        send(0, 0, 8'h1C);
        idle(6);
        check("release_none", {7'b0, key_valid}, 8'h00);

        // table of single keys under different modifier combinations
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].cp) send(1, 0, 8'h58);
            if (tbl[i].sh) send(1, 0, 8'h59);
            if (tbl[i].ct) send(1, 0, 8'h14);
            send(1, tbl[i].ext, tbl[i].sc);
            send(0, tbl[i].ext, tbl[i].sc);
            if (tbl[i].sh) send(0, 0, 8'h59);
            if (tbl[i].ct) send(0, 0, 8'h14);
            if (tbl[i].cp) begin send(1, 0, 8'h58); send(0, 0, 8'h58); end
            idle(6);
            check("tbl_valid", {7'b0, key_valid}, {7'b0, tbl[i].has});
            if (tbl[i].has) begin
                check("tbl_code", {1'b0, key_code}, {1'b0, tbl[i].exp});
                ack_tick();
                check("tbl_ack", {7'b0, key_valid}, 8'h00);
            end
            idle(3);
            check("tbl_single", {7'b0, key_valid}, 8'h00);
        end

        // six back-to-back spaces with no ack: one latched, four queued, one dropped
        ovf_before = ovf_cnt;
        for (int i = 0; i < 6; i++) send(1, 0, 8'h29);
        idle(6);
        check("ovf_pulses", 8'(ovf_cnt - ovf_before), 8'h01);
        got = 0;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (!key_valid && w < 20) begin tick(); w++; end
            check("drain_valid", {7'b0, key_valid}, 8'h01);
            check("drain_code", {1'b0, key_code}, 8'h20);
            if (key_valid) got++;
            ack_tick();
            check("drain_gap", {7'b0, key_valid}, 8'h00);
        end
        idle(6);
        check("drain_count", 8'(got), 8'h05);
        check("drain_empty", {7'b0, key_valid}, 8'h00);

        // reset with three queued plus one latched, caps toggled off
        send(1, 0, 8'h58);
        for (int i = 0; i < 4; i++) send(1, 0, 8'h16);
        idle(6);
        check("pre_rst_valid", {7'b0, key_valid}, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_valid", {7'b0, key_valid}, 8'h00);
        check("rst_code2", {1'b0, key_code}, 8'h00);
        check("rst_upcase2", {7'b0, upcase}, 8'h01);
        idle(8);
        check("post_rst_quiet", {7'b0, key_valid}, 8'h00);

        // reset while an event is still in the pipeline
        send(1, 0, 8'h29);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(6);
        check("rst_midpipe", {7'b0, key_valid}, 8'h00);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            key_ack = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 40) begin
                if ($urandom_range(0, 9) == 0)
                    ps2_key = {~ps2_key[10], 1'b1, 1'b1, ($urandom_range(0, 1) == 0) ? 8'h6B : 8'h74};
                else
                    ps2_key = {~ps2_key[10], ($urandom_range(0, 9) < 7), 1'b0,
                               pool[$urandom_range(0, 11)]};
            end
            tick();
        end
        key_ack = 1'b0;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
